// File: rtl/cursor_overlay_pkg.sv
// Shared display constants, sync payload type and distance helper for the cursor overlay.
package cursor_overlay_pkg;

  localparam int unsigned HCOORD_W         = 11;
  localparam int unsigned VCOORD_W         = 10;
  localparam int unsigned DIST_W           = 12;
  localparam int unsigned H_ACTIVE_DEF     = 800;
  localparam int unsigned V_ACTIVE_DEF     = 600;
  localparam int unsigned H_INIT           = 400;
  localparam int unsigned V_INIT           = 300;
  localparam int unsigned ARM_LEN_DEF      = 8;
  localparam int unsigned BLINK_FRAMES_DEF = 30;
  localparam int unsigned PIX_W_DEF        = 24;
  localparam logic [PIX_W_DEF-1:0] CURSOR_COLOR_DEF = 24'hFF0000;

  // Timing signals that travel alongside the pixel through the pipeline
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, blank: 1'b1};

  // Unsigned absolute difference; operands are zero-extended so it never wraps
  function automatic logic [DIST_W-1:0] abs_diff(input logic [DIST_W-1:0] a,
                                                 input logic [DIST_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/cursor_overlay_frame_ticker.sv
// Frame ticker: detects vsync falling edges and derives the blink phase from a frame counter.
module cursor_overlay_frame_ticker
  import cursor_overlay_pkg::*;
#(
  parameter int unsigned BLINK_FRAMES = BLINK_FRAMES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_vsync,
  output logic o_vsync_fall_c,
  output logic o_blink_phase
);

  localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic             r_vsync_q;
  logic [CNT_W-1:0] r_frame_cnt;
  logic             r_blink_phase;

  // Falling edge of active-low vsync marks the start of a new frame
  assign o_vsync_fall_c = r_vsync_q & ~i_vsync;
  assign o_blink_phase  = r_blink_phase;

  // Edge history, frame counter and blink phase toggle every BLINK_FRAMES frames
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vsync_q     <= 1'b1;
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b1;
    end else begin
      r_vsync_q <= i_vsync;
      if (o_vsync_fall_c) begin
        if (r_frame_cnt == CNT_LAST) begin
          r_frame_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_frame_cnt <= r_frame_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/cursor_overlay.sv
// Crosshair cursor overlay on the pixel stream with per-frame position latch and 2-cycle latency.
module cursor_overlay
  import cursor_overlay_pkg::*;
#(
  parameter int unsigned          H_ACTIVE     = H_ACTIVE_DEF,
  parameter int unsigned          V_ACTIVE     = V_ACTIVE_DEF,
  parameter int unsigned          ARM_LEN      = ARM_LEN_DEF,
  parameter int unsigned          BLINK_FRAMES = BLINK_FRAMES_DEF,
  parameter int unsigned          PIX_W        = PIX_W_DEF,
  parameter logic [PIX_W-1:0]     CURSOR_COLOR = PIX_W'(CURSOR_COLOR_DEF)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [HCOORD_W-1:0] x_pos,
  input  logic [VCOORD_W-1:0] y_pos,
  input  logic                cursor_en,
  input  logic                blink_en,
  input  logic [HCOORD_W-1:0] hcount,
  input  logic [VCOORD_W-1:0] vcount,
  input  logic                hsync,
  input  logic                vsync,
  input  logic                blank,
  input  logic [PIX_W-1:0]    pixel_in,
  output logic [PIX_W-1:0]    pixel_out,
  output logic                hsync_out,
  output logic                vsync_out,
  output logic                blank_out
);

  localparam logic [HCOORD_W-1:0] X_MAX  = HCOORD_W'(H_ACTIVE - 1);
  localparam logic [VCOORD_W-1:0] Y_MAX  = VCOORD_W'(V_ACTIVE - 1);
  localparam logic [DIST_W-1:0]   ARM_D  = DIST_W'(ARM_LEN);

  logic                w_vsync_fall;
  logic                w_blink_phase;
  logic [DIST_W-1:0]   w_dx;
  logic [DIST_W-1:0]   w_dy;
  logic                w_hit;
  logic                w_vis;

  logic [HCOORD_W-1:0] r_cx;
  logic [VCOORD_W-1:0] r_cy;

  logic [PIX_W-1:0]    r_pixel1;
  sync_t               r_sync1;
  logic                r_hit1;
  logic                r_vis1;

  logic [PIX_W-1:0]    r_pixel2;
  sync_t               r_sync2;

  cursor_overlay_frame_ticker #(
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_frame_ticker (
    .clk            (clk),
    .rst            (rst),
    .i_vsync        (vsync),
    .o_vsync_fall_c (w_vsync_fall),
    .o_blink_phase  (w_blink_phase)
  );

  // Latch the clamped cursor centre once per frame
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cx <= HCOORD_W'(H_INIT);
      r_cy <= VCOORD_W'(V_INIT);
    end else if (w_vsync_fall) begin
      r_cx <= (x_pos > X_MAX) ? X_MAX : x_pos;
      r_cy <= (y_pos > Y_MAX) ? Y_MAX : y_pos;
    end
  end

  // Crosshair window test and visibility for the current pixel
  always_comb begin
    w_dx  = abs_diff(DIST_W'(hcount), DIST_W'(r_cx));
    w_dy  = abs_diff(DIST_W'(vcount), DIST_W'(r_cy));
    w_hit = ((vcount == r_cy) && (w_dx <= ARM_D)) ||
            ((hcount == r_cx) && (w_dy <= ARM_D));
    w_vis = cursor_en & (w_blink_phase | ~blink_en);
  end

  // Stage 1: register hit/visibility with the pixel and timing signals
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pixel1 <= '0;
      r_sync1  <= SYNC_IDLE;
      r_hit1   <= 1'b0;
      r_vis1   <= 1'b0;
    end else begin
      r_pixel1 <= pixel_in;
      r_sync1  <= '{hsync: hsync, vsync: vsync, blank: blank};
      r_hit1   <= w_hit;
      r_vis1   <= w_vis;
    end
  end

  // Stage 2: composite the cursor colour inside the active area
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pixel2 <= '0;
      r_sync2  <= SYNC_IDLE;
    end else begin
      r_pixel2 <= (r_hit1 && r_vis1 && !r_sync1.blank) ? CURSOR_COLOR : r_pixel1;
      r_sync2  <= r_sync1;
    end
  end

  assign pixel_out = r_pixel2;
  assign hsync_out = r_sync2.hsync;
  assign vsync_out = r_sync2.vsync;
  assign blank_out = r_sync2.blank;

endmodule

// File: tb/tb_cursor_overlay.sv
// Directed self-checking bench for cursor_overlay.
module tb_cursor_overlay;

  localparam logic [23:0] CC = 24'hFF0000;
  localparam logic [23:0] BG = 24'h123456;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] x_pos;
  logic [9:0]  y_pos;
  logic        cursor_en;
  logic        blink_en;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hsync;
  logic        vsync;
  logic        blank;
  logic [23:0] pixel_in;
  logic [23:0] pixel_out;
  logic        hsync_out;
  logic        vsync_out;
  logic        blank_out;

  int n_cmp = 0;
  int n_bad = 0;

  cursor_overlay dut (
    .clk       (clk),
    .rst       (rst),
    .x_pos     (x_pos),
    .y_pos     (y_pos),
    .cursor_en (cursor_en),
    .blink_en  (blink_en),
    .hcount    (hcount),
    .vcount    (vcount),
    .hsync     (hsync),
    .vsync     (vsync),
    .blank     (blank),
    .pixel_in  (pixel_in),
    .pixel_out (pixel_out),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out),
    .blank_out (blank_out)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one pixel and wait out the 2-cycle latency
  task automatic drive_px(input logic [10:0] h, input logic [9:0] v,
                          input logic b, input logic [23:0] p);
    hcount   = h;
    vcount   = v;
    blank    = b;
    pixel_in = p;
    tick(2);
  endtask

  task automatic vsync_pulse();
    vsync = 1'b0;
    tick(1);
    vsync = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    rst = 1'b1; x_pos = 11'd123; y_pos = 10'd300;
    cursor_en = 1'b1; blink_en = 1'b0;
    hcount = 11'd400; vcount = 10'd300; hsync = 1'b1; vsync = 1'b1;
    blank = 1'b0; pixel_in = BG;
    tick(3);
    n_cmp++; if (pixel_out !== 24'h0) begin n_bad++; $display("FAIL reset_pixel got %h exp %h", pixel_out, 24'h0); end
    n_cmp++; if (hsync_out !== 1'b1) begin n_bad++; $display("FAIL reset_hsync got %b exp 1", hsync_out); end
    n_cmp++; if (vsync_out !== 1'b1) begin n_bad++; $display("FAIL reset_vsync got %b exp 1", vsync_out); end
    n_cmp++; if (blank_out !== 1'b1) begin n_bad++; $display("FAIL reset_blank got %b exp 1", blank_out); end
    rst = 1'b0;
    drive_px(11'd400, 10'd300, 1'b0, BG);
    n_cmp++; if (pixel_out !== CC) begin n_bad++; $display("FAIL reset_centre got %h exp %h", pixel_out, CC); end
    drive_px(11'd123, 10'd200, 1'b0, BG);
    n_cmp++; if (pixel_out !== BG) begin n_bad++; $display("FAIL reset_not_123 got %h exp %h", pixel_out, BG); end
  endtask

  task automatic test_latch();
    logic [10:0] hs [0:6];
    logic [9:0]  vs [0:6];
    logic        hit[0:6];
    hs = '{11'd108, 11'd100, 11'd109, 11'd100, 11'd100, 11'd92, 11'd91};
    vs = '{10'd50,  10'd42,  10'd50,  10'd41,  10'd50,  10'd50, 10'd50};
    hit = '{1'b1,   1'b1,    1'b0,    1'b0,    1'b1,    1'b1,   1'b0};
    x_pos = 11'd100; y_pos = 10'd50;
    vsync_pulse();
    for (int i = 0; i < 7; i++) begin
      drive_px(hs[i], vs[i], 1'b0, BG);
      n_cmp++;
      if (pixel_out !== (hit[i] ? CC : BG)) begin
        n_bad++;
        $display("FAIL latch_pt(%0d,%0d) got %h exp %h", hs[i], vs[i], pixel_out, hit[i] ? CC : BG);
      end
    end
  endtask

  task automatic test_hold();
    x_pos = 11'd200;
    drive_px(11'd100, 10'd50, 1'b0, BG);
    n_cmp++; if (pixel_out !== CC) begin n_bad++; $display("FAIL hold_old got %h exp %h", pixel_out, CC); end
    drive_px(11'd200, 10'd50, 1'b0, BG);
    n_cmp++; if (pixel_out !== BG) begin n_bad++; $display("FAIL hold_new_early got %h exp %h", pixel_out, BG); end
    vsync_pulse();
    drive_px(11'd200, 10'd50, 1'b0, BG);
    n_cmp++; if (pixel_out !== CC) begin n_bad++; $display("FAIL hold_moved got %h exp %h", pixel_out, CC); end
    drive_px(11'd100, 10'd50, 1'b0, BG);
    n_cmp++; if (pixel_out !== BG) begin n_bad++; $display("FAIL hold_old_gone got %h exp %h", pixel_out, BG); end
  endtask

  task automatic test_clamp();
    x_pos = 11'd900; y_pos = 10'd700;
    vsync_pulse();
    drive_px(11'd799, 10'd599, 1'b0, BG);
    n_cmp++; if (pixel_out !== CC) begin n_bad++; $display("FAIL clamp_centre got %h exp %h", pixel_out, CC); end
    drive_px(11'd791, 10'd599, 1'b0, BG);
    n_cmp++; if (pixel_out !== CC) begin n_bad++; $display("FAIL clamp_arm_l got %h exp %h", pixel_out, CC); end
    drive_px(11'd790, 10'd599, 1'b0, BG);
    n_cmp++; if (pixel_out !== BG) begin n_bad++; $display("FAIL clamp_arm_l_out got %h exp %h", pixel_out, BG); end
    drive_px(11'd799, 10'd591, 1'b0, BG);
    n_cmp++; if (pixel_out !== CC) begin n_bad++; $display("FAIL clamp_arm_u got %h exp %h", pixel_out, CC); end
    x_pos = 11'd0; y_pos = 10'd0;
    vsync_pulse();
    for (int h = 0; h <= 8; h++) begin
      drive_px(11'(h), 10'd0, 1'b0, BG);
      n_cmp++; if (pixel_out !== CC) begin n_bad++; $display("FAIL edge_arm_h%0d got %h exp %h", h, pixel_out, CC); end
    end
    drive_px(11'd9, 10'd0, 1'b0, BG);
    n_cmp++; if (pixel_out !== BG) begin n_bad++; $display("FAIL edge_arm_end got %h exp %h", pixel_out, BG); end
    drive_px(11'd0, 10'd8, 1'b0, BG);
    n_cmp++; if (pixel_out !== CC) begin n_bad++; $display("FAIL edge_arm_v got %h exp %h", pixel_out, CC); end
    drive_px(11'd1023, 10'd0, 1'b1, BG);
    n_cmp++; if (pixel_out !== BG) begin n_bad++; $display("FAIL edge_nowrap got %h exp %h", pixel_out, BG); end
  endtask

  task automatic test_blink();
    logic [23:0] exp_px;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    x_pos = 11'd100; y_pos = 10'd50;
    blink_en = 1'b1; cursor_en = 1'b1;
    for (int f = 1; f <= 60; f++) begin
      vsync_pulse();
      drive_px(11'd100, 10'd50, 1'b0, BG);
      exp_px = (f < 30 || f == 60) ? CC : BG;
      n_cmp++;
      if (pixel_out !== exp_px) begin
        n_bad++;
        $display("FAIL blink_frame%0d got %h exp %h", f, pixel_out, exp_px);
      end
    end
    for (int f = 0; f < 30; f++) vsync_pulse();
    drive_px(11'd100, 10'd50, 1'b0, BG);
    n_cmp++; if (pixel_out !== BG) begin n_bad++; $display("FAIL blink_hidden got %h exp %h", pixel_out, BG); end
    blink_en = 1'b0;
    drive_px(11'd100, 10'd50, 1'b0, BG);
    n_cmp++; if (pixel_out !== CC) begin n_bad++; $display("FAIL blink_off_vis got %h exp %h", pixel_out, CC); end
    cursor_en = 1'b0;
    drive_px(11'd100, 10'd50, 1'b0, BG);
    n_cmp++; if (pixel_out !== BG) begin n_bad++; $display("FAIL cursor_off got %h exp %h", pixel_out, BG); end
    cursor_en = 1'b1;
  endtask

  task automatic test_pipeline();
    logic [23:0] hp [0:31];
    logic        hh [0:31];
    logic        hv [0:31];
    logic        hb [0:31];
    for (int i = 0; i < 32; i++) begin
      hp[i] = 24'($urandom);
      hh[i] = 1'($urandom);
      hv[i] = 1'($urandom);
      hb[i] = 1'($urandom);
      pixel_in = hp[i]; hsync = hh[i]; vsync = hv[i]; blank = hb[i];
      hcount = 11'($urandom_range(200, 799));
      vcount = 10'($urandom_range(200, 599));
      tick(1);
      if (i >= 1) begin
        n_cmp++;
        if (pixel_out !== hp[i-1] || hsync_out !== hh[i-1] ||
            vsync_out !== hv[i-1] || blank_out !== hb[i-1]) begin
          n_bad++;
          $display("FAIL pipe_cycle%0d got %h/%b%b%b exp %h/%b%b%b", i,
                   pixel_out, hsync_out, vsync_out, blank_out,
                   hp[i-1], hh[i-1], hv[i-1], hb[i-1]);
        end
      end
    end
    pixel_in = 24'hABCDEF; hsync = 1'b0; vsync = 1'b1; blank = 1'b0;
    hcount = 11'd600; vcount = 10'd400;
    tick(2);
    rst = 1'b1;
    tick(1);
    n_cmp++; if (pixel_out !== 24'h0) begin n_bad++; $display("FAIL midrst_pixel got %h exp %h", pixel_out, 24'h0); end
    n_cmp++; if (hsync_out !== 1'b1 || vsync_out !== 1'b1) begin n_bad++; $display("FAIL midrst_syncs got %b%b exp 11", hsync_out, vsync_out); end
    n_cmp++; if (blank_out !== 1'b1) begin n_bad++; $display("FAIL midrst_blank got %b exp 1", blank_out); end
    rst = 1'b0;
    tick(1);
    n_cmp++; if (pixel_out !== 24'h0) begin n_bad++; $display("FAIL resume_early got %h exp %h", pixel_out, 24'h0); end
    tick(1);
    n_cmp++; if (pixel_out !== 24'hABCDEF || hsync_out !== 1'b0 || blank_out !== 1'b0) begin
      n_bad++; $display("FAIL resume_stream got %h/%b%b exp abcdef/00", pixel_out, hsync_out, blank_out);
    end
  endtask

  initial begin
    test_reset();
    test_latch();
    test_hold();
    test_clamp();
    test_blink();
    test_pipeline();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
